serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Multi-cycle, digit-serial N-bit subtractor with a borrow in and a borrow out.
- Computes diff = a - b - bin, W bits per clock, through one W-bit slice carry chain.
- Companion to the combinational N-bit adders. Used where area matters more than latency.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- N, 32, operand and result width; must be a multiple of W.
- W, 8, digit (slice) width processed per cycle; 1 <= W <= N.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a/b/bin are valid.
- in_ready  output  1  block can accept operands.
- a  input  N  minuend.
- b  input  N  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  diff/bout are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  N  (a - b - bin) mod 2^N.
- bout  output  1  borrow out: 1 iff unsigned a < b + bin.

Behaviour:
- Reset is asynchronous, active-low; the only clock is clk.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - diff = 0, bout = 0.
  - slice counter = 0; internal operand registers = 0.
- FSM states:
  - IDLE:
    - in_ready = 1.
    - On in_valid & in_ready: register a, b and the borrow chain (borrow = bin), clear the slice counter, go to BUSY.
  - BUSY:
    - in_ready = 0.
    - Each cycle computes slice k (bits k*W .. k*W+W-1) as a_k + ~b_k + ~borrow.
    - The low W bits go into diff slice k.
    - The new borrow is the inverted carry out of the slice.
    - The counter increments.
    - After slice N/W-1 is written: bout = final borrow, go to DONE.
  - DONE:
    - out_valid = 1; diff and bout are held stable.
    - On out_valid & out_ready: go to IDLE, deassert out_valid.
- Latency: out_valid rises exactly N/W cycles after the accepting clock edge (4 cycles for N=32, W=8).
- Throughput: one operation per N/W + 2 cycles minimum. No overlap: in_ready is 0 in BUSY and in DONE.
- Backpressure:
  - out_ready low in DONE holds diff/bout/out_valid unchanged indefinitely.
  - in_valid is ignored while in_ready = 0.
- Inputs a, b and bin are sampled only on the accepting edge. Later changes to them have no effect on the operation in flight.
- diff slices not yet computed in BUSY hold their previous values. diff is defined only while out_valid = 1.
- Arithmetic is modular. The borrow propagates across slices exactly as a full N-bit ripple subtract would.
- Special cases:
  - W == N: BUSY lasts 1 cycle.
  - W == 1: BUSY lasts N cycles.
- Reset asserted mid-operation (BUSY or DONE): immediate return to reset values and the result is discarded. The first cycle after deassertion is IDLE with in_ready = 1.
- Elaboration-time check: N % W != 0 or W == 0 is a fatal error.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVERFLOW_EN.
- When defined:
  - Adds output port ovf (1 bit), reset value 0.
  - ovf is the two's-complement overflow of a - b - bin: XOR of the carry into and out of bit N-1 of the final slice.
  - ovf is registered alongside bout and valid while out_valid = 1.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- N=32, W=8: a=5, b=3, bin=0 -> diff=0x00000002, bout=0, out_valid exactly 4 cycles after the accept edge.
- a=0x00000100, b=0x000000FF, bin=1 -> diff=0x00000000, bout=0 (borrow crosses the slice 0/1 boundary).
- a=0, b=0, bin=1 -> diff=0xFFFFFFFF, bout=1. Also a=0, b=1, bin=0 -> diff=0xFFFFFFFF, bout=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE, toggling a/b/in_valid meanwhile -> diff/bout/out_valid stable, in_ready=0.
  - Then raise out_ready -> IDLE the next cycle with in_ready=1.
- Reset mid-operation: assert rst_n=0 in the 2nd BUSY cycle -> out_valid=0, in_ready=1, diff=0 asynchronously. A new op (a=10, b=4) afterwards -> diff=6, bout=0.
- With SERIAL_SUBTRACTOR_OVERFLOW_EN:
  - a=0x80000000, b=1 -> diff=0x7FFFFFFF, ovf=1.
  - a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, ovf=1.
  - a=5, b=3 -> ovf=0.
  - Repeat the suite with W=1 and W=32 -> latency 32 and 1 respectively.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for serial_subtractor.
// The master side supplies operands and consumes results; the slave side is the subtractor.
// Optional ovf signal is present only when SERIAL_SUBTRACTOR_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic         ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
`else
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial N-bit subtractor: diff = a - b - bin, W bits per clock through one
// W-bit slice, with valid/ready handshakes on operand and result sides.
// Optional feature macro: SERIAL_SUBTRACTOR_OVERFLOW_EN adds a registered
// two's-complement overflow flag (ovf) alongside bout.
module serial_subtractor #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int SLICES = (W >= 1) ? (N / W) : 1;
  localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int IW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(SLICES - 1);

  // Reject slice widths that do not tile the operand exactly
  if ((W < 1) || (W > N) || (((W < 1) ? 0 : (N % W)) != 0)) begin : gParamCheck
    $fatal(1, "serial_subtractor: W must satisfy 1 <= W <= N and N %% W == 0");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  opA_q;
  logic [N-1:0]  opB_q;
  logic          borrow_q;
  logic [CW-1:0] count_q;
  logic [N-1:0]  diff_q;
  logic          bout_q;
  logic          inReady_q;
  logic          outValid_q;
  logic          ovf_q;

  logic [IW-1:0] sliceBase;
  logic [W-1:0]  aSlice;
  logic [W-1:0]  bSlice;
  logic [W:0]    sliceSum;
  logic          borrow_d;
  logic          sliceOvf;

  // Slice datapath: a_k + ~b_k + ~borrow; the inverted carry out is the next borrow
  always_comb begin
    sliceBase = IW'(int'(count_q) * W);
    aSlice    = opA_q[sliceBase +: W];
    bSlice    = opB_q[sliceBase +: W];
    sliceSum  = {1'b0, aSlice} + {1'b0, ~bSlice} + {{W{1'b0}}, ~borrow_q};
    borrow_d  = ~sliceSum[W];
    // Carry into the slice MSB recovered from the MSB sum bit, XORed with carry out
    sliceOvf  = sliceSum[W] ^ (aSlice[W-1] ^ ~bSlice[W-1] ^ sliceSum[W-1]);
  end

  // Control FSM with registered handshake outputs and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      borrow_q   <= 1'b0;
      count_q    <= '0;
      diff_q     <= '0;
      bout_q     <= 1'b0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && inReady_q) begin
            opA_q     <= bus.a;
            opB_q     <= bus.b;
            borrow_q  <= bus.bin;
            count_q   <= '0;
            inReady_q <= 1'b0;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          diff_q[sliceBase +: W] <= sliceSum[W-1:0];
          borrow_q               <= borrow_d;
          count_q                <= count_q + CW'(1);
          if (count_q == LAST_SLICE) begin
            bout_q     <= borrow_d;
            ovf_q      <= sliceOvf;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (outValid_q && bus.out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          outValid_q <= 1'b0;
          inReady_q  <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = inReady_q;
  assign bus.out_valid = outValid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  assign bus.ovf = ovf_q;
`else
  logic unusedOvf;
  assign unusedOvf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors plus randomized
// operations compared against an arithmetic reference model.
// Honors SERIAL_SUBTRACTOR_OVERFLOW_EN for the ovf checks.
module tb_serial_subtractor #(
  parameter int W = 8
);

  localparam int N       = 32;
  localparam int LATENCY = N / W;

  logic clk;
  logic rst_n;

  int compareCount;
  int mismatchCount;

  serial_subtractor_if #(.N(N)) bus ();

  serial_subtractor #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: plain wide-integer arithmetic on the operands
  function automatic void refModel(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic bin, output logic [N-1:0] d,
                                   output logic bo, output logic ov);
    longint ua;
    longint ub;
    longint sa;
    longint sb;
    longint ures;
    longint sres;
    ua   = longint'({32'd0, a});
    ub   = longint'({32'd0, b});
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ures = ua - ub - longint'(bin);
    sres = sa - sb - longint'(bin);
    d    = ures[N-1:0];
    bo   = (ua < ub + longint'(bin));
    ov   = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
  endfunction

  // One full operation: accept, latency, result, backpressure hold, release
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic bin, input int hold);
    logic [N-1:0] expDiff;
    logic         expBout;
    logic         expOvf;
    int           lat;
    refModel(a, b, bin, expDiff, expBout, expOvf);

    @(negedge clk);
    checkOutput("in_ready idle", 64'(bus.in_ready), 64'd1);
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.bin      = 1'($urandom_range(0, 1));
    checkOutput("in_ready busy", 64'(bus.in_ready), 64'd0);

    lat = 0;
    while (!bus.out_valid && lat < 4 * LATENCY + 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 64'(lat), 64'(LATENCY));
    checkOutput("diff", 64'(bus.diff), 64'(expDiff));
    checkOutput("bout", 64'(bus.bout), 64'(expBout));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    checkOutput("ovf", 64'(bus.ovf), 64'(expOvf));
`endif

    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a        = $urandom;
      bus.b        = $urandom;
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold out_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("hold in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("hold diff", 64'(bus.diff), 64'(expDiff));
      checkOutput("hold bout", 64'(bus.bout), 64'(expBout));
    end

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput("release out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("release in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  function automatic logic [N-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Main sequence: reset, directed vectors, mid-op reset, random ops
  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;

    #12;
    checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset diff", 64'(bus.diff), 64'd0);
    checkOutput("reset bout", 64'(bus.bout), 64'd0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    checkOutput("reset ovf", 64'(bus.ovf), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(32'd5, 32'd3, 1'b0, 0);
    applyStimulus(32'h0000_0100, 32'h0000_00FF, 1'b1, 0);
    applyStimulus(32'd0, 32'd0, 1'b1, 0);
    applyStimulus(32'd0, 32'd1, 1'b0, 0);
    applyStimulus(32'h8000_0000, 32'd1, 1'b0, 0);
    applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    applyStimulus(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 5);

    @(negedge clk);
    bus.a        = 32'd100;
    bus.b        = 32'd1;
    bus.bin      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("midreset in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("midreset diff", 64'(bus.diff), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'd10, 32'd4, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(pickOperand(), pickOperand(), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
